// File: rtl/sdram_req_arbiter.sv
// Two-client round-robin arbiter serialising read/write commands
// to the SDRAM controller, one transaction in flight at a time.
module sdram_req_arbiter #(
  parameter int ROW_W   = 13,
  parameter int COL_W   = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ROW_W-1:0]  a_row,
  input  logic [COL_W-1:0]  a_col,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ROW_W-1:0]  b_row,
  input  logic [COL_W-1:0]  b_col,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              sd_rd_start,
  output logic              sd_wr_start,
  output logic [ROW_W-1:0]  sd_row,
  output logic [COL_W-1:0]  sd_col,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic              sd_rd_valid,
  input  logic [DATA_W-1:0] sd_rd_data,
  input  logic              sd_wr_valid,
  output logic              busy,
  output logic [1:0]        grant
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last_b;
  logic [1:0]        r_grant;
  logic              r_we;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [TW-1:0]     r_timer;

  logic w_any;
  logic w_pick_b;
  logic w_match;
  logic w_tout;

  assign w_any    = a_req | b_req;
  // B wins alone, or on a tie when A was the last winner
  assign w_pick_b = b_req & (~a_req | ~r_last_b);
  assign w_match  = r_we ? sd_wr_valid : sd_rd_valid;
  assign w_tout   = (r_timer == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    sd_rd_start = 1'b0;
    sd_wr_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        sd_rd_start = ~r_we;
        sd_wr_start = r_we;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (w_match || w_tout) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
      r_grant  <= '0;
      r_we     <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_timer  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= {w_pick_b, ~w_pick_b};
            r_we    <= w_pick_b ? b_we    : a_we;
            r_row   <= w_pick_b ? b_row   : a_row;
            r_col   <= w_pick_b ? b_col   : a_col;
            r_wdata <= w_pick_b ? b_wdata : a_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
        end
        S_WAIT: begin
          // a matching valid beats a simultaneous timeout
          if (w_match) begin
            r_err <= 1'b0;
            if (!r_we) r_rdata <= sd_rd_data;
          end else if (w_tout) begin
            r_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE: begin
          r_last_b <= r_grant[1];
          r_grant  <= '0;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign sd_row   = r_row;
  assign sd_col   = r_col;
  assign sd_wdata = r_wdata;

  assign a_ack   = (r_state == S_DONE) & r_grant[0];
  assign b_ack   = (r_state == S_DONE) & r_grant[1];
  assign a_err   = a_ack & r_err;
  assign b_err   = b_ack & r_err;
  assign a_rdata = a_ack ? r_rdata : '0;
  assign b_rdata = b_ack ? r_rdata : '0;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: vector table plus
// hand-written timeout and mid-transaction reset sequences.
module tb_sdram_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_req = 0, a_we = 0;
  logic [12:0] a_row = 13'd5;
  logic [8:0]  a_col = 9'd3;
  logic [7:0]  a_wdata = 8'h5A;
  logic       a_ack, a_err;
  logic [7:0] a_rdata;
  logic       b_req = 0, b_we = 0;
  logic [12:0] b_row = 13'd7;
  logic [8:0]  b_col = 9'd9;
  logic [7:0]  b_wdata = 8'h3C;
  logic       b_ack, b_err;
  logic [7:0] b_rdata;
  logic       sd_rd_start, sd_wr_start;
  logic [12:0] sd_row;
  logic [8:0]  sd_col;
  logic [7:0]  sd_wdata;
  logic       sd_rd_valid = 0, sd_wr_valid = 0;
  logic [7:0] sd_rd_data = 0;
  logic       busy;
  logic [1:0] grant;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_req_arbiter #(
    .ROW_W(13), .COL_W(9), .DATA_W(8), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_row(a_row), .a_col(a_col),
    .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_row(b_row), .b_col(b_col),
    .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .sd_rd_start(sd_rd_start), .sd_wr_start(sd_wr_start),
    .sd_row(sd_row), .sd_col(sd_col), .sd_wdata(sd_wdata),
    .sd_rd_valid(sd_rd_valid), .sd_rd_data(sd_rd_data),
    .sd_wr_valid(sd_wr_valid), .busy(busy), .grant(grant)
  );

  typedef struct {
    bit          rst;
    logic        ar, aw, br, bw, rv, wv;
    logic [7:0]  rd;
    logic [24:0] exp;
    bit          lat;
    logic [12:0] row;
    logic [8:0]  col;
    logic [7:0]  wd;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [24:0] E(
    input logic bz, input logic [1:0] g, input logic rs, input logic ws,
    input logic aa, input logic ae, input logic [7:0] ard,
    input logic ba, input logic be, input logic [7:0] brd);
    return {bz, g, rs, ws, aa, ae, ard, ba, be, brd};
  endfunction

  function automatic vec_t mk(
    input bit rst, input logic ar, aw, br, bw, rv, wv,
    input logic [7:0] rd, input logic [24:0] exp, input bit lat,
    input logic [12:0] row, input logic [8:0] col, input logic [7:0] wd);
    vec_t v;
    v.rst = rst; v.ar = ar; v.aw = aw; v.br = br; v.bw = bw;
    v.rv = rv; v.wv = wv; v.rd = rd; v.exp = exp;
    v.lat = lat; v.row = row; v.col = col; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [24:0] w_act;
  assign w_act = {busy, grant, sd_rd_start, sd_wr_start, a_ack, a_err,
                  a_rdata, b_ack, b_err, b_rdata};

  localparam logic [24:0] IDLE_E = 25'd0;

  initial begin
    int ack_cyc;

    // A read, valid two cycles after start
    tbl.push_back(mk(1,1,0,0,0,0,0,8'h00, IDLE_E, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,8'h00,
      E(1,2'b01,1,0,0,0,8'h00,0,0,8'h00), 1,13'd5,9'd3,8'h5A));
    tbl.push_back(mk(0,1,0,0,0,0,0,8'h00,
      E(1,2'b01,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1,0,8'hA5,
      E(1,2'b01,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,8'h00,
      E(1,2'b01,0,0,1,0,8'hA5,0,0,8'h00), 1,13'd5,9'd3,8'h5A));
    tbl.push_back(mk(0,0,0,0,0,0,0,8'h00, IDLE_E, 0,0,0,0));
    // tie from reset, then A re-requests alongside pending B
    tbl.push_back(mk(1,1,0,1,0,0,0,8'h00, IDLE_E, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0,8'h00,
      E(1,2'b01,1,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,1,0,8'h11,
      E(1,2'b01,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,8'h00,
      E(1,2'b01,0,0,1,0,8'h11,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0,8'h00, IDLE_E, 0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,0,0,8'h00,
      E(1,2'b10,1,0,0,0,8'h00,0,0,8'h00), 1,13'd7,9'd9,8'h3C));
    tbl.push_back(mk(0,1,0,1,0,1,0,8'h22,
      E(1,2'b10,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,8'h00,
      E(1,2'b10,0,0,0,0,8'h00,1,0,8'h22), 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,8'h00, IDLE_E, 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,8'h00,
      E(1,2'b01,1,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,1,0,8'h33,
      E(1,2'b01,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,8'h00,
      E(1,2'b01,0,0,1,0,8'h33,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,8'h00, IDLE_E, 0,0,0,0));
    // B write; a stray rd_valid in WAIT must be ignored
    tbl.push_back(mk(0,0,0,1,1,0,0,8'h00, IDLE_E, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,0,8'h00,
      E(1,2'b10,0,1,0,0,8'h00,0,0,8'h00), 1,13'd7,9'd9,8'h3C));
    tbl.push_back(mk(0,0,0,1,1,1,0,8'hFF,
      E(1,2'b10,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,0,8'h00,
      E(1,2'b10,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,1,8'h00,
      E(1,2'b10,0,0,0,0,8'h00,0,0,8'h00), 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,8'h00,
      E(1,2'b10,0,0,0,0,8'h00,1,0,8'h00), 1,13'd7,9'd9,8'h3C));
    tbl.push_back(mk(0,0,0,0,0,0,0,8'h00, IDLE_E, 0,0,0,0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      a_req = tbl[i].ar; a_we = tbl[i].aw;
      b_req = tbl[i].br; b_we = tbl[i].bw;
      sd_rd_valid = tbl[i].rv; sd_wr_valid = tbl[i].wv;
      sd_rd_data = tbl[i].rd;
      #1;
      chk($sformatf("vec%0d", i), 64'(w_act), 64'(tbl[i].exp));
      if (tbl[i].lat)
        chk($sformatf("vec%0d_latch", i),
            64'({sd_row, sd_col, sd_wdata}),
            64'({tbl[i].row, tbl[i].col, tbl[i].wd}));
    end

    // A read with no controller response: error ack 64 cycles after ISSUE
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0;
    ack_cyc = -1;
    for (int c = 1; c < 200 && ack_cyc < 0; c++) begin
      @(negedge clk);
      #1;
      if (c == 1) chk("to_start", 64'(sd_rd_start), 64'd1);
      if (a_ack) begin
        ack_cyc = c;
        chk("to_err", 64'(a_err), 64'd1);
        chk("to_rdata", 64'(a_rdata), 64'd0);
        a_req = 1'b0;
      end
    end
    chk("to_latency", 64'(ack_cyc), 64'd65);

    // next A request after timeout completes normally
    @(negedge clk);
    a_req = 1'b1;
    @(negedge clk);
    #1 chk("post_to_start", 64'({grant, sd_rd_start}), 64'({2'b01, 1'b1}));
    @(negedge clk);
    sd_rd_valid = 1'b1; sd_rd_data = 8'h5C;
    @(negedge clk);
    sd_rd_valid = 1'b0; sd_rd_data = 8'h00;
    #1 chk("post_to_ack", 64'({a_ack, a_err, a_rdata}),
           64'({1'b1, 1'b0, 8'h5C}));
    a_req = 1'b0;

    // reset during WAIT; A was last winner, so a stale pointer picks B
    @(negedge clk);
    a_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("rst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 chk("rst_outs", 64'({busy, grant, a_ack, sd_row, sd_col}), 64'd0);
    a_req = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    sd_rd_valid = 1'b1; sd_rd_data = 8'h77;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("rst_quiet%0d", c), 64'({busy, a_ack, b_ack}), 64'd0);
      @(negedge clk);
      sd_rd_valid = 1'b0;
    end
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    #1 chk("rst_tie_grant", 64'({grant, sd_rd_start}), 64'({2'b01, 1'b1}));
    @(negedge clk);
    sd_rd_valid = 1'b1; sd_rd_data = 8'h99;
    @(negedge clk);
    sd_rd_valid = 1'b0; sd_rd_data = 8'h00;
    #1 chk("rst_tie_ack", 64'({a_ack, b_ack, a_rdata}),
           64'({1'b1, 1'b0, 8'h99}));
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
